result_display_ctrl: RTL

RESULT_DISPLAY_CTRL -- requirements
Module: result_display_ctrl

---
 rtl/result_display_ctrl_pkg.sv | 22 ++
 rtl/result_display_ctrl_max_tracker.sv | 54 +++++
 rtl/result_display_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/result_display_ctrl_pkg.sv
// Shared types and sizing helpers for the result display controller.
package result_display_ctrl_pkg;

    // Controller states: two voting-side states and two result-side states.
    typedef enum logic [1:0] {
        VOTE_IDLE  = 2'd0,
        VOTE_FLASH = 2'd1,
        RES_EVAL   = 2'd2,
        RES_SHOW   = 2'd3
    } state_t;

    // Width of a candidate index: max(1, clog2(n)).
    function automatic int idx_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/result_display_ctrl_max_tracker.sv
// Sequential argmax/tie evaluator: consumes one (index, count) pair per step.
// The first step (index 0) loads unconditionally; later steps replace the
// maximum only on a strictly greater count, so ties keep the lower index.
module max_tracker
    import result_display_ctrl_pkg::*;
#(
    parameter  int NUM_CAND = 4,
    parameter  int VOTE_W   = 8,
    localparam int IDX_W    = idx_w(NUM_CAND)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [IDX_W-1:0]  i_index,
    input  logic [VOTE_W-1:0] i_count,
    output logic [IDX_W-1:0]  o_winner_idx,
    output logic              o_tie,
    output logic              o_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    logic [VOTE_W-1:0] r_max;
    logic [IDX_W-1:0]  r_win;
    logic              r_tie;

    // Running maximum, winner index and tie flag; cleared by reset or start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_start) begin
            r_max <= '0;
            r_win <= '0;
            r_tie <= 1'b0;
        end else if (i_step) begin
            if (i_index == '0) begin
                r_max <= i_count;
                r_win <= '0;
                r_tie <= 1'b0;
            end else if (i_count > r_max) begin
                r_max <= i_count;
                r_win <= i_index;
                r_tie <= 1'b0;
            end else if (i_count == r_max) begin
                r_tie <= 1'b1;
            end
        end
    end

    assign o_winner_idx = r_win;
    assign o_tie        = r_tie;
    // The step on the last index completes the evaluation at this edge.
    assign o_done       = i_step && (i_index == LAST_IDX);

endmodule

// File: rtl/result_display_ctrl.sv
// Result display controller: flashes the LEDs on each accepted vote, and in
// result mode evaluates the winner then shows counts (button, scan or winner).
// Handshake note: valid_vote_casted is a single-cycle pulse with no back-
// pressure; it is acted on only in the voting states with mode=0.
module result_display_ctrl
    import result_display_ctrl_pkg::*;
#(
    parameter  int NUM_CAND     = 4,
    parameter  int VOTE_W       = 8,
    parameter  int FLASH_CYCLES = 100,
    parameter  int SCAN_CYCLES  = 200,
    localparam int IDX_W        = idx_w(NUM_CAND)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       mode,
    input  logic                       valid_vote_casted,
    input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
    input  logic [NUM_CAND-1:0]        cand_button_level,
    input  logic                       scan_en,
    output logic [VOTE_W-1:0]          leds,
    output logic [IDX_W-1:0]           shown_idx,
    output logic [IDX_W-1:0]           winner_idx,
    output logic                       tie,
    output logic                       result_valid,
    output logic [1:0]                 dbg_state
);

    localparam int FLASH_W = cnt_w(FLASH_CYCLES);
    localparam int SCAN_W  = cnt_w(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CAND - 1);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);
    localparam logic [SCAN_W-1:0]  DWELL_LAST = SCAN_W'(SCAN_CYCLES - 1);

    state_t               r_state, w_next;
    logic [FLASH_W-1:0]   r_flash_cnt, w_flash_cnt_nxt;
    logic [IDX_W-1:0]     r_eval_idx, w_eval_idx_nxt;
    logic [IDX_W-1:0]     r_scan_idx, w_scan_idx_nxt;
    logic [SCAN_W-1:0]    r_dwell_cnt, w_dwell_nxt;
    logic [NUM_CAND*VOTE_W-1:0] r_votes_q;
    logic [VOTE_W-1:0]    r_leds, w_leds_nxt;
    logic [IDX_W-1:0]     r_shown, w_shown_nxt;
    logic                 r_result_valid;
    logic                 w_start, w_step, w_done;
    logic                 w_votes_changed, w_any_btn;
    logic [IDX_W-1:0]     w_btn_idx;
    logic [IDX_W-1:0]     w_winner_idx;
    logic                 w_tie;
    logic [VOTE_W-1:0]    w_counts [NUM_CAND];

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_unpack
        assign w_counts[g] = cand_votes[g*VOTE_W +: VOTE_W];
    end

    assign w_votes_changed = (cand_votes != r_votes_q);
    assign w_any_btn       = |cand_button_level;

    // Lowest-index pressed button wins the display.
    always_comb begin
        w_btn_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (cand_button_level[i]) begin
                w_btn_idx = IDX_W'(i);
            end
        end
    end

    max_tracker #(
        .NUM_CAND (NUM_CAND),
        .VOTE_W   (VOTE_W)
    ) u_max_tracker (
        .i_clk        (clock),
        .i_rst_n      (reset_n),
        .i_start      (w_start),
        .i_step       (w_step),
        .i_index      (r_eval_idx),
        .i_count      (w_counts[r_eval_idx]),
        .o_winner_idx (w_winner_idx),
        .o_tie        (w_tie),
        .o_done       (w_done)
    );

    // Next-state, counter updates and the display value to register.
    always_comb begin
        w_next          = r_state;
        w_flash_cnt_nxt = r_flash_cnt;
        w_eval_idx_nxt  = r_eval_idx;
        w_scan_idx_nxt  = r_scan_idx;
        w_dwell_nxt     = r_dwell_cnt;
        w_start         = 1'b0;
        w_step          = 1'b0;
        w_leds_nxt      = '0;
        w_shown_nxt     = '0;
        unique case (r_state)
            VOTE_IDLE: begin
                if (mode) begin
                    w_next          = RES_EVAL;
                    w_start         = 1'b1;
                    w_eval_idx_nxt  = '0;
                    w_flash_cnt_nxt = '0;
                end else if (valid_vote_casted) begin
                    w_next          = VOTE_FLASH;
                    w_flash_cnt_nxt = FLASH_LOAD;
                end
            end
            VOTE_FLASH: begin
                w_leds_nxt = '1;
                if (mode) begin
                    w_next          = RES_EVAL;
                    w_start         = 1'b1;
                    w_eval_idx_nxt  = '0;
                    w_flash_cnt_nxt = '0;
                end else if (valid_vote_casted) begin
                    w_flash_cnt_nxt = FLASH_LOAD;
                end else if (r_flash_cnt <= FLASH_W'(1)) begin
                    w_next          = VOTE_IDLE;
                    w_flash_cnt_nxt = '0;
                end else begin
                    w_flash_cnt_nxt = r_flash_cnt - 1'b1;
                end
            end
            RES_EVAL: begin
                if (!mode) begin
                    w_next         = VOTE_IDLE;
                    w_eval_idx_nxt = '0;
                end else begin
                    w_step = 1'b1;
                    if (w_done) begin
                        w_next         = RES_SHOW;
                        w_eval_idx_nxt = '0;
                        w_scan_idx_nxt = '0;
                        w_dwell_nxt    = '0;
                    end else begin
                        w_eval_idx_nxt = r_eval_idx + 1'b1;
                    end
                end
            end
            RES_SHOW: begin
                if (!mode) begin
                    w_next         = VOTE_IDLE;
                    w_scan_idx_nxt = '0;
                    w_dwell_nxt    = '0;
                end else if (w_votes_changed) begin
                    w_next         = RES_EVAL;
                    w_start        = 1'b1;
                    w_eval_idx_nxt = '0;
                    w_scan_idx_nxt = '0;
                    w_dwell_nxt    = '0;
                end else if (w_any_btn) begin
                    w_leds_nxt     = w_counts[w_btn_idx];
                    w_shown_nxt    = w_btn_idx;
                    w_scan_idx_nxt = '0;
                    w_dwell_nxt    = '0;
                end else if (scan_en) begin
                    w_leds_nxt  = w_counts[r_scan_idx];
                    w_shown_nxt = r_scan_idx;
                    if (r_dwell_cnt >= DWELL_LAST) begin
                        w_dwell_nxt    = '0;
                        w_scan_idx_nxt = (r_scan_idx == LAST_IDX) ? '0 : r_scan_idx + 1'b1;
                    end else begin
                        w_dwell_nxt = r_dwell_cnt + 1'b1;
                    end
                end else begin
                    w_leds_nxt     = w_counts[w_winner_idx];
                    w_shown_nxt    = w_winner_idx;
                    w_scan_idx_nxt = '0;
                    w_dwell_nxt    = '0;
                end
            end
            default: begin
                w_next = VOTE_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= VOTE_IDLE;
            r_flash_cnt    <= '0;
            r_eval_idx     <= '0;
            r_scan_idx     <= '0;
            r_dwell_cnt    <= '0;
            r_votes_q      <= '0;
            r_leds         <= '0;
            r_shown        <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_flash_cnt    <= w_flash_cnt_nxt;
            r_eval_idx     <= w_eval_idx_nxt;
            r_scan_idx     <= w_scan_idx_nxt;
            r_dwell_cnt    <= w_dwell_nxt;
            r_votes_q      <= cand_votes;
            r_leds         <= w_leds_nxt;
            r_shown        <= w_shown_nxt;
            r_result_valid <= (w_next == RES_SHOW);
        end
    end

    assign leds         = r_leds;
    assign shown_idx    = r_shown;
    assign winner_idx   = w_winner_idx;
    assign tie          = w_tie;
    assign result_valid = r_result_valid;
    assign dbg_state    = r_state;

endmodule
